// File: rtl/div_engine.sv
// Multi-cycle unsigned divider: restoring division, one quotient bit per clock.
// A zero divisor finishes immediately with quotient all ones and the dividend as remainder.
module div_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eng_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             eng_done,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Shifted partial remainder with the next dividend bit appended. The top bit
  // is kept so the compare stays exact for divisors close to 2^WIDTH-1.
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   sub;
  logic             q_bit;
  logic [WIDTH:0]   prem_next;
  logic [WIDTH-1:0] dvd_next;

  always_comb begin
    trial     = {prem_q, dvd_q[WIDTH-1]};
    q_bit     = (trial >= {2'b00, dvs_q});
    sub       = trial[WIDTH:0] - {1'b0, dvs_q};
    prem_next = q_bit ? sub : trial[WIDTH:0];
    // dvd_q doubles as the quotient shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    dvd_next  = {dvd_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (eng_start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prem_d = prem_next;
        dvd_d  = dvd_next;
        cnt_d  = cnt_q + 1'b1;
        // Result ports only change here, so intermediate values never show.
        if (cnt_q == LAST_ITER) begin
          state_d     = S_DONE;
          quotient_d  = dvd_next;
          remainder_d = prem_next[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign eng_done  = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule
